// File: rtl/ysyx_23060025_ifu_pkg.sv
// -----------------------------------------------------------------------------
// ysyx_23060025_ifu_pkg
//   Shared constants and types for the instruction fetch unit.
//   IFU_RESET_PC   : PC loaded on reset
//   IFU_ADDR_WIDTH : default PC / fetch address width
//   ifu_state_e    : fetch FSM state encoding (3 bits)
// -----------------------------------------------------------------------------
package ysyx_23060025_ifu_pkg;

   localparam logic [31:0] IFU_RESET_PC   = 32'h3000_0000;
   localparam int unsigned IFU_ADDR_WIDTH = 32;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_REQ        = 3'd1,
      S_WAIT       = 3'd2,
      S_HOLD       = 3'd3,
      S_FENCE      = 3'd4,
      S_FENCE_WAIT = 3'd5
   } ifu_state_e;

endpackage

// File: rtl/ysyx_23060025_ifu.sv
// -----------------------------------------------------------------------------
// ysyx_23060025_ifu
//   Instruction fetch unit. Holds the PC, issues one icache access per
//   instruction over psel/pready, buffers the returned word and hands
//   {inst, pc} to the IDU over a valid/ready handshake. EXU redirects and
//   fence.i are applied here; the icache invalidate is pulsed only while no
//   access is outstanding.
//
// Ports
//   clock, reset            : single clock, synchronous active-high reset
//   out_paddr / out_psel    : fetch request to icache (psel is a 1-cycle pulse)
//   in_pready / in_prdata   : icache response, data valid in the pready cycle
//   out_fence_flag          : 1-cycle icache invalidate pulse
//   in_jmp_valid / target   : EXU redirect pulse, target word-aligned here
//   in_fence_req            : fence.i, always accompanied by in_jmp_valid
//   out_valid / in_ready    : instruction buffer handshake to IDU
//   out_inst / out_pc       : buffered instruction and its PC
// -----------------------------------------------------------------------------
module ysyx_23060025_ifu
   import ysyx_23060025_ifu_pkg::*;
#(
   parameter int unsigned               ADDR_WIDTH = IFU_ADDR_WIDTH,
   parameter logic [ADDR_WIDTH-1:0]     RESET_PC   = ADDR_WIDTH'(IFU_RESET_PC)
) (
   input  logic                  clock,
   input  logic                  reset,
   output logic [ADDR_WIDTH-1:0] out_paddr,
   output logic                  out_psel,
   input  logic                  in_pready,
   input  logic [31:0]           in_prdata,
   output logic                  out_fence_flag,
   input  logic                  in_jmp_valid,
   input  logic [ADDR_WIDTH-1:0] in_jmp_target,
   input  logic                  in_fence_req,
   output logic                  out_valid,
   input  logic                  in_ready,
   output logic [31:0]           out_inst,
   output logic [ADDR_WIDTH-1:0] out_pc
);

   ifu_state_e            state_q, state_d;

   logic [ADDR_WIDTH-1:0] pc_q;
   logic [31:0]           inst_q;
   logic [ADDR_WIDTH-1:0] inst_pc_q;

   logic                  pend_valid_q;
   logic                  pend_fence_q;
   logic [ADDR_WIDTH-1:0] pend_target_q;

   logic [ADDR_WIDTH-1:0] jmp_target_aligned;
   logic                  redirect_any;
   logic                  redirect_fence;
   logic [ADDR_WIDTH-1:0] redirect_target;

   assign jmp_target_aligned = {in_jmp_target[ADDR_WIDTH-1:2], 2'b00};

   // A redirect arriving in the very cycle the icache answers is folded into
   // the pending one so it is not lost; the newest redirect always wins.
   assign redirect_any    = pend_valid_q | in_jmp_valid;
   assign redirect_fence  = in_jmp_valid ? in_fence_req       : pend_fence_q;
   assign redirect_target = in_jmp_valid ? jmp_target_aligned : pend_target_q;

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  state_d = S_REQ;
         S_REQ:   state_d = S_WAIT;
         S_WAIT: begin
            if (in_pready) begin
               if (redirect_any) begin
                  state_d = redirect_fence ? S_FENCE : S_REQ;
               end else begin
                  state_d = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            // A redirect overrides the sequential PC even if the IDU takes the
            // buffered instruction in the same cycle.
            if (in_jmp_valid) begin
               state_d = in_fence_req ? S_FENCE : S_REQ;
            end else if (in_ready) begin
               state_d = S_REQ;
            end
         end
         S_FENCE:      state_d = S_FENCE_WAIT;
         S_FENCE_WAIT: state_d = S_REQ;
         default:      state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------ outputs
   always_comb begin
      out_psel       = (state_q == S_REQ);
      out_fence_flag = (state_q == S_FENCE);
      out_valid      = (state_q == S_HOLD);
      out_paddr      = pc_q;
      out_inst       = inst_q;
      out_pc         = inst_pc_q;
   end

   // ------------------------------------------------ PC, buffer, pending redirect
   always_ff @(posedge clock) begin
      if (reset) begin
         pc_q          <= RESET_PC;
         inst_q        <= '0;
         inst_pc_q     <= '0;
         pend_valid_q  <= 1'b0;
         pend_fence_q  <= 1'b0;
         pend_target_q <= '0;
      end else begin
         unique case (state_q)
            S_REQ: begin
               // The access cannot be aborted; remember the redirect instead.
               if (in_jmp_valid) begin
                  pend_valid_q  <= 1'b1;
                  pend_fence_q  <= in_fence_req;
                  pend_target_q <= jmp_target_aligned;
               end
            end
            S_WAIT: begin
               if (in_pready) begin
                  if (redirect_any) begin
                     pc_q <= redirect_target;
                  end else begin
                     inst_q    <= in_prdata;
                     inst_pc_q <= pc_q;
                  end
                  pend_valid_q <= 1'b0;
                  pend_fence_q <= 1'b0;
               end else if (in_jmp_valid) begin
                  pend_valid_q  <= 1'b1;
                  pend_fence_q  <= in_fence_req;
                  pend_target_q <= jmp_target_aligned;
               end
            end
            S_HOLD: begin
               if (in_jmp_valid) begin
                  pc_q <= jmp_target_aligned;
               end else if (in_ready) begin
                  pc_q <= pc_q + ADDR_WIDTH'(4);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // The icache only answers an outstanding request.
   pready_only_in_wait : assert property (
      @(posedge clock) disable iff (reset) in_pready |-> (state_q == S_WAIT)
   );

endmodule
